// File: rtl/ikaopll_bus_sequencer_if.sv
// Host request handshake and IKAOPLL write-bus signals for the bus sequencer.
// The master side is the host/core pair and the slave side is the sequencer.
interface ikaopll_bus_sequencer_if #(
  parameter int FIFO_DEPTH_LOG2 = 4
);
  logic                     req_valid;
  logic                     req_ready;
  logic [7:0]               req_addr;
  logic [7:0]               req_data;
  logic [FIFO_DEPTH_LOG2:0] fifo_level;
  logic                     busy;
  logic                     cs_n;
  logic                     wr_n;
  logic                     a0;
  logic [7:0]               d;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, fifo_level, busy, cs_n, wr_n, a0, d
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, fifo_level, busy, cs_n, wr_n, a0, d
  );
endinterface

// File: rtl/ikaopll_bus_sequencer.sv
// Queues (addr, data) register writes and replays each as a timed YM2413 address/data
// write pair; all strobe widths and waits are counted in phiM ticks.
module ikaopll_bus_sequencer #(
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int WR_PULSE        = 2,
  parameter int ADDR_WAIT       = 12,
  parameter int DATA_WAIT       = 84
) (
  input  logic                    i_EMUCLK,
  input  logic                    i_RST,
  input  logic                    i_phiM_PCEN_n,
  ikaopll_bus_sequencer_if.slave  bus
);
  localparam int DEPTH   = 1 << FIFO_DEPTH_LOG2;
  localparam int WAIT_MX = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
  localparam int CNT_MAX = (WAIT_MX > WR_PULSE) ? WAIT_MX : WR_PULSE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [FIFO_DEPTH_LOG2:0] FULL_LEVEL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(WR_PULSE - 1);
  localparam logic [CNT_W-1:0] AWAIT_LD = CNT_W'(ADDR_WAIT - 1);
  localparam logic [CNT_W-1:0] DWAIT_LD = CNT_W'(DATA_WAIT - 1);

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } req_t;

  typedef enum logic [2:0] {
    IDLE, A_SETUP, A_STROBE, A_WAIT, D_SETUP, D_STROBE, D_WAIT
  } state_t;

  req_t                       mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   level;
  req_t                       head;
  logic                       tick, push, pop, fifo_full, fifo_empty;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       data_q;
  logic             cs_n_q, wr_n_q, a0_q;
  logic [7:0]       d_q;
  logic             cs_n_nxt, wr_n_nxt, a0_nxt;
  logic [7:0]       d_nxt;

  assign tick       = ~i_phiM_PCEN_n;
  assign fifo_full  = (level == FULL_LEVEL);
  assign fifo_empty = (level == '0);
  assign push       = bus.req_valid & ~fifo_full;
  assign head       = mem[rd_ptr];

  always_ff @(posedge i_EMUCLK) begin
    if (push) mem[wr_ptr] <= '{addr: bus.req_addr, data: bus.req_data};
  end

  // State register: FIFO pointers, FSM, counter and registered bus outputs.
  always_ff @(posedge i_EMUCLK) begin
    if (i_RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      state  <= IDLE;
      cnt    <= '0;
      data_q <= '0;
      cs_n_q <= 1'b1;
      wr_n_q <= 1'b1;
      a0_q   <= 1'b0;
      d_q    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        data_q <= head.data;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      cs_n_q <= cs_n_nxt;
      wr_n_q <= wr_n_nxt;
      a0_q   <= a0_nxt;
      d_q    <= d_nxt;
    end
  end

  // Next state; counters only ever decrement from a nonzero value, so they park at 0.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pop       = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = A_SETUP;
          end
        end
        A_SETUP: begin
          state_nxt = A_STROBE;
          cnt_nxt   = PULSE_LD;
        end
        A_STROBE: begin
          if (cnt == '0) begin
            state_nxt = A_WAIT;
            cnt_nxt   = AWAIT_LD;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        A_WAIT: begin
          if (cnt == '0) state_nxt = D_SETUP;
          else           cnt_nxt   = cnt - 1'b1;
        end
        D_SETUP: begin
          state_nxt = D_STROBE;
          cnt_nxt   = PULSE_LD;
        end
        D_STROBE: begin
          if (cnt == '0) begin
            state_nxt = D_WAIT;
            cnt_nxt   = DWAIT_LD;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        D_WAIT: begin
          if (cnt != '0) begin
            cnt_nxt = cnt - 1'b1;
          end else if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = A_SETUP;
          end else begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output logic: next values of the registered bus pins.
  always_comb begin
    cs_n_nxt = cs_n_q;
    wr_n_nxt = wr_n_q;
    a0_nxt   = a0_q;
    d_nxt    = d_q;
    if (tick) begin
      case (state)
        IDLE, D_WAIT: begin
          if (pop) begin
            cs_n_nxt = 1'b0;
            wr_n_nxt = 1'b1;
            a0_nxt   = 1'b0;
            d_nxt    = head.addr;
          end else if (state == D_WAIT && cnt == '0) begin
            cs_n_nxt = 1'b1;
            wr_n_nxt = 1'b1;
          end
        end
        A_SETUP, D_SETUP: wr_n_nxt = 1'b0;
        A_STROBE, D_STROBE: begin
          if (cnt == '0) begin
            wr_n_nxt = 1'b1;
            cs_n_nxt = 1'b1;
          end
        end
        A_WAIT: begin
          if (cnt == '0) begin
            cs_n_nxt = 1'b0;
            a0_nxt   = 1'b1;
            d_nxt    = data_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = ~fifo_full;
  assign bus.fifo_level = level;
  assign bus.busy       = (state != IDLE) | ~fifo_empty;
  assign bus.cs_n       = cs_n_q;
  assign bus.wr_n       = wr_n_q;
  assign bus.a0         = a0_q;
  assign bus.d          = d_q;
endmodule
